// File: rtl/inst_fetch_buffer_pkg.sv
// Shared constants and state encoding for the instruction fetch buffer and the Fetch stage.
package inst_fetch_buffer_pkg;

  localparam int INST_BYTES = 10;
  localparam int WORD_BYTES = 8;
  localparam int INSTBUS_W  = INST_BYTES * 8;
  localparam int LINE_WORDS = 3;
  localparam int LINE_W     = LINE_WORDS * WORD_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Slots that must be valid for a window starting at byte offset off.
  function automatic logic [2:0] need_mask(input logic [2:0] off);
    return (off == 3'd7) ? 3'b111 : 3'b011;
  endfunction

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// CPU-side request/response and ROM-side req/ack signals of the instruction fetch buffer.
interface inst_fetch_buffer_if #(
  parameter int ADDR_W = 64
);
  import inst_fetch_buffer_pkg::*;

  logic                 req_i;
  logic [ADDR_W-1:0]    pc_i;
  logic                 flush_i;
  logic                 ready_o;
  logic                 inst_valid_o;
  logic [INSTBUS_W-1:0] inst_o;
  logic                 err_o;
  logic                 rom_req_o;
  logic [ADDR_W-1:0]    rom_addr_o;
  logic                 rom_ack_i;
  logic [63:0]          rom_data_i;
  logic                 rom_err_i;

  modport slave (
    input  req_i, pc_i, flush_i, rom_ack_i, rom_data_i, rom_err_i,
    output ready_o, inst_valid_o, inst_o, err_o, rom_req_o, rom_addr_o
  );

  modport master (
    output req_i, pc_i, flush_i, rom_ack_i, rom_data_i, rom_err_i,
    input  ready_o, inst_valid_o, inst_o, err_o, rom_req_o, rom_addr_o
  );

endinterface

// File: rtl/inst_window_extract.sv
// Byte shifter: picks the 10-byte instruction window at byte offset off out of {w2,w1,w0}.
module inst_window_extract
  import inst_fetch_buffer_pkg::*;
(
  input  logic [LINE_W-1:0]    line,
  input  logic [2:0]           off,
  output logic [INSTBUS_W-1:0] window
);

  // The highest byte a window can reach is 7+9=16; the rest of w2 never contributes.
  logic unused_hi;
  assign unused_hi = ^line[LINE_W-1:8*17];

  always_comb begin
    window = '0;
    for (int i = 0; i < INST_BYTES; i++) begin
      window[INSTBUS_W-1-8*i -: 8] = line[8*(int'(off) + i) +: 8];
    end
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: 3-word line buffer in front of the instruction ROM, returning a 10-byte window per PC.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_buffer_if.slave bus
);

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(WORD_BYTES);

  state_t                state, state_n;
  logic [2:0]            v, v_n;
  logic [ADDR_W-1:0]     base_tag, base_tag_n;
  logic [2:0]            off, off_n;
  logic                  err_q, err_n;
  logic                  flush_pend, flush_pend_n;
  logic [INSTBUS_W-1:0]  inst_hold;
  logic [63:0]           w [LINE_WORDS];

  logic                  do_shift, do_wr;
  logic [1:0]            k;
  logic [2:0]            missing, v_fill, fill_mask, req_mask, v_shift;
  logic [ADDR_W-1:0]     req_base;
  logic                  same_line, next_line;
  logic [INSTBUS_W-1:0]  window, resp_window;

  assign req_base  = {bus.pc_i[ADDR_W-1:3], 3'b000};
  assign req_mask  = need_mask(bus.pc_i[2:0]);
  assign same_line = (req_base == base_tag);
  assign next_line = (req_base == base_tag + WORD_STEP);
  assign v_shift   = {1'b0, v[2:1]};
  assign fill_mask = need_mask(off);
  assign missing   = ~v & fill_mask;
  assign v_fill    = v | (3'b001 << k);

  always_comb begin
    if (missing[0])      k = 2'd0;
    else if (missing[1]) k = 2'd1;
    else                 k = 2'd2;
  end

  inst_window_extract u_extract (
    .line   ({w[2], w[1], w[0]}),
    .off    (off),
    .window (window)
  );

  assign resp_window = err_q ? '0 : window;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      v          <= '0;
      base_tag   <= '0;
      off        <= '0;
      err_q      <= 1'b0;
      flush_pend <= 1'b0;
      inst_hold  <= '0;
    end else begin
      state      <= state_n;
      v          <= v_n;
      base_tag   <= base_tag_n;
      off        <= off_n;
      err_q      <= err_n;
      flush_pend <= flush_pend_n;
      if (state == ST_RESP) inst_hold <= resp_window;
    end
  end

  // Line words carry no reset; their valid bits above decide whether they are used.
  always_ff @(posedge clk) begin
    if (do_shift) begin
      w[0] <= w[1];
      w[1] <= w[2];
    end
    if (do_wr) w[k] <= bus.rom_data_i;
  end

  always_comb begin
    state_n      = state;
    v_n          = v;
    base_tag_n   = base_tag;
    off_n        = off;
    err_n        = err_q;
    flush_pend_n = flush_pend;
    do_shift     = 1'b0;
    do_wr        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.flush_i) v_n = '0;
        if (bus.req_i) begin
          off_n        = bus.pc_i[2:0];
          err_n        = 1'b0;
          flush_pend_n = 1'b0;
          if (bus.flush_i || !(same_line || next_line)) begin
            v_n        = '0;
            base_tag_n = req_base;
            state_n    = ST_FILL;
          end else if (same_line) begin
            state_n = ((v & req_mask) == req_mask) ? ST_RESP : ST_FILL;
          end else begin
            do_shift   = 1'b1;
            v_n        = v_shift;
            base_tag_n = req_base;
            state_n    = ((v_shift & req_mask) == req_mask) ? ST_RESP : ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (bus.flush_i) flush_pend_n = 1'b1;
        if (bus.rom_ack_i) begin
          // A flush seen at any point of the fill discards the returning word and the request.
          if (bus.flush_i || flush_pend) begin
            v_n          = '0;
            flush_pend_n = 1'b0;
            state_n      = ST_IDLE;
          end else if (bus.rom_err_i) begin
            v_n     = '0;
            err_n   = 1'b1;
            state_n = ST_RESP;
          end else begin
            do_wr = 1'b1;
            v_n   = v_fill;
            if ((v_fill & fill_mask) == fill_mask) state_n = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (bus.flush_i) v_n = '0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o      = (state == ST_IDLE);
    bus.inst_valid_o = (state == ST_RESP);
    bus.err_o        = (state == ST_RESP) && err_q;
    bus.rom_req_o    = (state == ST_FILL);
    bus.rom_addr_o   = (state == ST_FILL) ? base_tag + ADDR_W'({k, 3'b000}) : '0;
    bus.inst_o       = (state == ST_RESP) ? resp_window : inst_hold;
  end

endmodule
